ibex_instr_wb_bridge: RTL and testbench

- Wishbone B4 pipelined master that converts the Ibex instruction-fetch port (req/gnt/rvalid) into Wishbone cycles.
- Sits directly upstream of the instruction memory slave. Drives cyc/stb/adr and consumes its stall/ack/err/dat.
- Tracks outstanding transfers so that back-to-back fetches pipeline without bubbles.
- Optionally registers the response path for timing.

---
 rtl/ibex_instr_wb_bridge.sv | 112 +++++++++++
 tb/tb_ibex_instr_wb_bridge.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_instr_wb_bridge.sv
// Ibex instruction-fetch (req/gnt/rvalid) to Wishbone B4 pipelined read master.
// Tracks outstanding transfers and can optionally register the response path.
module ibex_instr_wb_bridge #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter bit          REG_RSP         = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    input  logic [31:0] instr_addr_i,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,

    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [31:0] wb_adr_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_dat_o,
    input  logic        wb_stall_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic [31:0] wb_dat_i,

    output logic        protocol_err_o
);

    localparam int unsigned      CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             protocol_err_q, protocol_err_d;
    logic             busy, can_issue, stb, accept, rsp, rsp_ok;

    always_comb begin
        busy      = (cnt_q != '0);
        can_issue = (cnt_q < CNT_MAX);
        // Strobe is gated by reset so the bus is quiet while held in reset.
        stb       = instr_req_i & can_issue & rst_ni;
        accept    = stb & ~wb_stall_i;
        rsp       = wb_ack_i | wb_err_i;
        rsp_ok    = rsp & busy;

        cnt_d = cnt_q;
        if (accept && !rsp_ok) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!accept && rsp_ok) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        protocol_err_d = protocol_err_q | (rsp & ~busy);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q          <= '0;
            protocol_err_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    assign wb_stb_o       = stb;
    assign wb_cyc_o       = stb | busy;
    assign wb_adr_o       = instr_addr_i;
    assign wb_we_o        = 1'b0;
    assign wb_sel_o       = 4'b1111;
    assign wb_dat_o       = 32'h0;
    assign instr_gnt_o    = accept;
    assign protocol_err_o = protocol_err_q;

    if (REG_RSP) begin : g_reg_rsp
        logic        rsp_valid_q, rsp_valid_d;
        logic        rsp_err_q, rsp_err_d;
        logic [31:0] rsp_data_q, rsp_data_d;

        always_comb begin
            rsp_valid_d = rsp_ok;
            rsp_data_d  = rsp_data_q;
            rsp_err_d   = rsp_err_q;
            if (rsp) begin
                rsp_data_d = wb_dat_i;
                rsp_err_d  = wb_err_i;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rsp_valid_q <= 1'b0;
                rsp_data_q  <= 32'h0;
                rsp_err_q   <= 1'b0;
            end else begin
                rsp_valid_q <= rsp_valid_d;
                rsp_data_q  <= rsp_data_d;
                rsp_err_q   <= rsp_err_d;
            end
        end

        assign instr_rvalid_o = rsp_valid_q;
        assign instr_rdata_o  = rsp_data_q;
        assign instr_err_o    = rsp_err_q;
    end else begin : g_comb_rsp
        assign instr_rvalid_o = rsp_ok;
        assign instr_rdata_o  = wb_dat_i;
        assign instr_err_o    = wb_err_i;
    end

endmodule

// File: tb/tb_ibex_instr_wb_bridge.sv
// Bench for ibex_instr_wb_bridge: a combinational-response and a registered-response
// instance share one randomized Wishbone slave and are checked against a queue-based model.
module tb_ibex_instr_wb_bridge;

    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [31:0] addr = 32'h0;
    logic        stall = 1'b0, ack = 1'b0, err = 1'b0;
    logic [31:0] dat = 32'h0;

    logic        gnt0, rv0, ierr0, cyc0, stb0, we0, perr0;
    logic [31:0] rdata0, adr0, wdat0;
    logic [3:0]  sel0;
    logic        gnt1, rv1, ierr1, cyc1, stb1, we1, perr1;
    logic [31:0] rdata1, adr1, wdat1;
    logic [3:0]  sel1;

    ibex_instr_wb_bridge #(.MAX_OUTSTANDING(MAXO), .REG_RSP(1'b0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .instr_req_i(req), .instr_gnt_o(gnt0), .instr_addr_i(addr),
        .instr_rvalid_o(rv0), .instr_rdata_o(rdata0), .instr_err_o(ierr0),
        .wb_cyc_o(cyc0), .wb_stb_o(stb0), .wb_adr_o(adr0), .wb_we_o(we0),
        .wb_sel_o(sel0), .wb_dat_o(wdat0), .wb_stall_i(stall), .wb_ack_i(ack),
        .wb_err_i(err), .wb_dat_i(dat), .protocol_err_o(perr0)
    );

    ibex_instr_wb_bridge #(.MAX_OUTSTANDING(MAXO), .REG_RSP(1'b1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .instr_req_i(req), .instr_gnt_o(gnt1), .instr_addr_i(addr),
        .instr_rvalid_o(rv1), .instr_rdata_o(rdata1), .instr_err_o(ierr1),
        .wb_cyc_o(cyc1), .wb_stb_o(stb1), .wb_adr_o(adr1), .wb_we_o(we1),
        .wb_sel_o(sel1), .wb_dat_o(wdat1), .wb_stall_i(stall), .wb_ack_i(ack),
        .wb_err_i(err), .wb_dat_i(dat), .protocol_err_o(perr1)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
    endfunction

    // Slave: accepted reads are answered in order after a random latency.
    typedef struct {
        logic [31:0] a;
        int          due;
    } pend_t;

    pend_t       slv_q[$];
    int          cyc_n = 0;
    int unsigned lat_min = 1, lat_max = 1, ack_pct = 100, stall_pct = 0, spur_pct = 0;
    bit          force_stall = 1'b0, spur_ack = 1'b0, keep_q = 1'b0;
    bit          acc_flag = 1'b0;
    logic [31:0] acc_addr = 32'h0;

    always @(posedge clk) begin
        pend_t h;
        cyc_n++;
        #2;
        if (acc_flag)
            slv_q.push_back('{a: acc_addr, due: cyc_n + int'($urandom_range(lat_max - 1, lat_min - 1))});
        ack = 1'b0;
        err = 1'b0;
        dat = $urandom;
        if (!rst_n) begin
            if (!keep_q) slv_q.delete();
        end else if (slv_q.size() == 0) begin
            if (spur_ack || ($urandom_range(0, 99) < spur_pct)) ack = 1'b1;
        end else if (slv_q[0].due <= cyc_n && $urandom_range(0, 99) < ack_pct) begin
            h = slv_q.pop_front();
            if (h.a[15]) err = 1'b1;
            else begin
                ack = 1'b1;
                dat = mem(h.a);
            end
        end
        stall = force_stall || ($urandom_range(0, 99) < stall_pct);
    end

    // Reference model: outstanding count, issue-order address queue, sticky fault flag,
    // and the one-cycle-delayed response seen by the registered instance.
    int          m_n = 0;
    bit          m_perr = 1'b0, m_rv1 = 1'b0, m_er1 = 1'b0;
    logic [31:0] m_rd1 = 32'h0;
    logic [31:0] iss_q[$];

    always @(negedge clk) begin
        bit e_stb, e_gnt, e_cyc, e_rv, rsp;
        logic [31:0] ea;
        if (!rst_n) begin
            chk1("rst_stb", stb0, 1'b0);
            chk1("rst_gnt", gnt0, 1'b0);
            chk1("rst_cyc", cyc0, 1'b0);
            chk1("rst_rvalid", rv0, 1'b0);
            chk1("rst_perr", perr0, 1'b0);
            chk1("rst_cyc_r", cyc1, 1'b0);
            chk1("rst_rvalid_r", rv1, 1'b0);
            chk1("rst_perr_r", perr1, 1'b0);
            m_n = 0; m_perr = 1'b0; m_rv1 = 1'b0; m_rd1 = 32'h0; m_er1 = 1'b0;
            iss_q.delete();
            acc_flag = 1'b0;
        end else begin
            e_stb = req && (m_n < MAXO);
            e_gnt = e_stb && !stall;
            e_cyc = e_stb || (m_n > 0);
            rsp   = ack || err;
            e_rv  = rsp && (m_n > 0);

            chk1("stb", stb0, e_stb);
            chk1("gnt", gnt0, e_gnt);
            chk1("cyc", cyc0, e_cyc);
            chk1("rvalid", rv0, e_rv);
            chk1("perr", perr0, m_perr);
            chk1("stb_r", stb1, e_stb);
            chk1("gnt_r", gnt1, e_gnt);
            chk1("cyc_r", cyc1, e_cyc);
            chk1("perr_r", perr1, m_perr);
            chk1("we", we0 | we1, 1'b0);
            chk32("sel", {28'h0, sel0 & sel1}, 32'hF);
            chk32("wdat", wdat0 | wdat1, 32'h0);
            if (e_stb) begin
                chk32("adr", adr0, addr);
                chk32("adr_r", adr1, addr);
            end
            if (e_rv) begin
                chk1("rsp_err", ierr0, err);
                if (iss_q.size() == 0) begin
                    chk1("rsp_without_issue", 1'b1, 1'b0);
                end else begin
                    ea = iss_q.pop_front();
                    if (!err) chk32("rdata", rdata0, mem(ea));
                end
            end
            chk1("rvalid_r", rv1, m_rv1);
            if (m_rv1) chk1("rsp_err_r", ierr1, m_er1);
            if (m_rv1 && !m_er1) chk32("rdata_r", rdata1, m_rd1);

            m_rv1 = e_rv;
            if (rsp) begin
                m_rd1 = dat;
                m_er1 = err;
            end
            if (rsp && m_n == 0) m_perr = 1'b1;
            if (e_gnt) iss_q.push_back(addr);
            m_n = m_n + int'(e_gnt) - int'(e_rv);
            acc_flag = e_gnt;
            acc_addr = addr;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    initial begin
        bit          holding;
        bit          seen;
        logic [31:0] ra;

        repeat (2) step();
        look();
        chk1("reset_perr", perr0, 1'b0);
        chk1("reset_cyc", cyc0, 1'b0);

        // Single fetch, 1-cycle slave
        step(); rst_n = 1'b1; req = 1'b1; addr = 32'h100;
        look();
        chk1("sf_gnt_c0", gnt0, 1'b1);
        chk1("sf_rvalid_c0", rv0, 1'b0);
        step(); req = 1'b0;
        look();
        chk1("sf_rvalid_c1", rv0, 1'b1);
        chk32("sf_rdata_c1", rdata0, mem(32'h100));
        chk1("sf_rvalid_r_c1", rv1, 1'b0);
        chk1("sf_cyc_c1", cyc0, 1'b1);
        step();
        look();
        chk1("sf_cyc_c2", cyc0, 1'b0);
        chk1("sf_rvalid_r_c2", rv1, 1'b1);
        chk32("sf_rdata_r_c2", rdata1, mem(32'h100));

        // Back-to-back fetches
        for (int i = 0; i < 4; i++) begin
            step(); req = 1'b1; addr = 32'(i * 4);
            look();
            chk1("b2b_gnt", gnt0, 1'b1);
            if (i > 0) begin
                chk1("b2b_rvalid", rv0, 1'b1);
                chk32("b2b_rdata", rdata0, mem(32'((i - 1) * 4)));
            end
        end
        step(); req = 1'b0;
        look();
        chk1("b2b_rvalid_last", rv0, 1'b1);
        chk32("b2b_rdata_last", rdata0, mem(32'hC));
        step();
        look();
        chk1("b2b_cyc_idle", cyc0, 1'b0);

        // Outstanding limit with 3-cycle slave
        lat_min = 3; lat_max = 3;
        step(); req = 1'b1; addr = 32'h200;
        look(); chk1("lim_gnt0", gnt0, 1'b1);
        step(); addr = 32'h204;
        look(); chk1("lim_gnt1", gnt0, 1'b1);
        step(); addr = 32'h208;
        look(); chk1("lim_stb_c2", stb0, 1'b0); chk1("lim_gnt_c2", gnt0, 1'b0);
        step();
        look(); chk1("lim_stb_c3", stb0, 1'b0); chk1("lim_rvalid_c3", rv0, 1'b1);
        step();
        look(); chk1("lim_gnt_c4", gnt0, 1'b1);
        step(); req = 1'b0;
        for (int k = 0; k < 20 && m_n != 0; k++) step();
        look(); chk1("lim_drained_cyc", cyc0, 1'b0);
        lat_min = 1; lat_max = 1;

        // Stall holds strobe and address
        step(); req = 1'b1; addr = 32'h40; force_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            look();
            chk1("stall_stb", stb0, 1'b1);
            chk1("stall_gnt", gnt0, 1'b0);
            chk32("stall_adr", adr0, 32'h40);
            step();
        end
        force_stall = 1'b0;
        look(); chk1("stall_release_gnt", gnt0, 1'b1);
        step(); req = 1'b0;
        step();
        look(); chk1("stall_cyc_idle", cyc0, 1'b0);

        // Bus error completion
        step(); req = 1'b1; addr = 32'h8000;
        look(); chk1("err_gnt", gnt0, 1'b1);
        step(); req = 1'b0;
        look(); chk1("err_rvalid", rv0, 1'b1); chk1("err_flag", ierr0, 1'b1);
        step();
        look();
        chk1("err_cyc_idle", cyc0, 1'b0);
        chk1("err_no_perr", perr0, 1'b0);
        chk1("err_rvalid_r", rv1, 1'b1);
        chk1("err_flag_r", ierr1, 1'b1);

        // Spurious ack sets the sticky flag; reset clears it
        step(); spur_ack = 1'b1;
        look(); chk1("spur_no_rvalid", rv0, 1'b0); chk1("spur_perr_c0", perr0, 1'b0);
        step(); spur_ack = 1'b0;
        look(); chk1("spur_perr_c1", perr0, 1'b1); chk1("spur_perr_r_c1", perr1, 1'b1);
        step();
        look(); chk1("spur_perr_held", perr0, 1'b1);
        step(); rst_n = 1'b0;
        #1;
        chk1("spur_perr_async_clr", perr0, 1'b0);
        chk1("spur_perr_r_async_clr", perr1, 1'b0);
        step(); rst_n = 1'b1;

        // Ack for a transfer issued before reset arrives after release
        lat_min = 3; lat_max = 3; keep_q = 1'b1;
        step(); req = 1'b1; addr = 32'h300;
        look(); chk1("late_gnt", gnt0, 1'b1);
        step(); req = 1'b0; rst_n = 1'b0;
        step(); rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            look();
            if (perr0) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        chk1("late_ack_perr", seen, 1'b1);
        lat_min = 1; lat_max = 1; keep_q = 1'b0;
        step(); rst_n = 1'b0;
        step(); rst_n = 1'b1;

        // Randomized traffic
        stall_pct = 25; ack_pct = 60; lat_min = 1; lat_max = 3; spur_pct = 2;
        holding = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            step();
            rst_n = ($urandom_range(0, 599) != 0);
            if (holding && acc_flag) holding = 1'b0;
            if (!holding) begin
                req = ($urandom_range(0, 99) < 70);
                ra = $urandom & 32'h0000_7FFC;
                if ($urandom_range(0, 7) == 0) ra[15] = 1'b1;
                addr = ra;
                holding = req;
            end
        end
        step(); rst_n = 1'b1; req = 1'b0;
        stall_pct = 0; ack_pct = 100; spur_pct = 0;
        repeat (10) step();
        look(); chk1("final_cyc_idle", cyc0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
